// File: rtl/rs_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared combinational root-square unit.
// Define RS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module rs_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [3*NUM_REQ-1:0] req_sel,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [31:0]          rs_a,
  output logic [2:0]           rs_sel,
  input  logic [31:0]          rs_s,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_s,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic [31:0]     r_rs_a;
  logic [2:0]      r_rs_sel;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_s;
  logic [ID_W-1:0] r_rsp_id;

  logic            w_any;
  logic [ID_W-1:0] w_gnt;
  logic            w_hs;
  logic [31:0]     w_a;
  logic [2:0]      w_sel;

`ifdef RS_ARB_FIXED_PRIO_EN
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_any = 1'b1;
        w_gnt = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_nxt_ptr;
  logic [ID_W-1:0] w_idx;
  int              w_sum;

  // Search starts at the pointer and wraps; the sum never exceeds 2*NUM_REQ-2.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_sum = 0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = int'(r_rr_ptr) + k;
      w_idx = (w_sum >= NUM_REQ) ? ID_W'(w_sum - NUM_REQ) : ID_W'(w_sum);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_nxt_ptr = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
`endif

  assign w_hs      = (r_state == S_IDLE) && !rst && w_any;
  assign req_ready = w_hs ? (NUM_REQ'(1) << w_gnt) : '0;

  always_comb begin
    w_a   = '0;
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_a   = req_a[32*i +: 32];
        w_sel = req_sel[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rs_a      <= '0;
      r_rs_sel    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_s     <= '0;
      r_rsp_id    <= '0;
`ifndef RS_ARB_FIXED_PRIO_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_rs_a   <= w_a;
            r_rs_sel <= w_sel;
            r_rsp_id <= w_gnt;
            r_cnt    <= CNT_INIT;
            r_state  <= S_EVAL;
`ifndef RS_ARB_FIXED_PRIO_EN
            r_rr_ptr <= w_nxt_ptr;
`endif
          end
        end
        // rs_a/rs_sel stay put while the external unit settles.
        S_EVAL: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_s     <= rs_s;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rs_a      = r_rs_a;
  assign rs_sel    = r_rs_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_s     = r_rsp_s;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != S_IDLE);

endmodule
